valrdy_demux8: RTL and testbench

- Routes a single val/rdy message stream to one of eight val/rdy output ports, selected per message by a 3-bit destination field.
- Sits at the distribution end of a datapath, where an 8-way mux gathers streams back together; the two blocks form a matched split/merge pair.
- Holds one message in a pipeline register, giving one-cycle latency and full throughput when the destination is ready.
- Keeps a running count of delivered messages for debug and performance counters.

---
 rtl/valrdy_demux8.sv | 59 +++++
 tb/tb_valrdy_demux8.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/valrdy_demux8.sv
// valrdy_demux8: one-entry pipelined val/rdy demultiplexer to eight output ports, with a delivered-message counter
//   clk_i           rising-edge clock
//   rst_ni          asynchronous active-low reset
//   in_val_i        input message valid
//   in_rdy_o        block can accept input this cycle
//   in_sel_i        destination port index, 0..7
//   in_msg_i        input payload
//   out_val_o       bit i = message valid on output port i (one-hot or zero)
//   out_rdy_i       bit i = consumer on port i ready
//   out_msg_o       payload shared by all output ports
//   deliver_count_o messages delivered since reset, wraps modulo 2^cbits
module valrdy_demux8 #(
  parameter int nbits = 16,
  parameter int cbits = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_val_i,
  output logic             in_rdy_o,
  input  logic [2:0]       in_sel_i,
  input  logic [nbits-1:0] in_msg_i,
  output logic [7:0]       out_val_o,
  input  logic [7:0]       out_rdy_i,
  output logic [nbits-1:0] out_msg_o,
  output logic [cbits-1:0] deliver_count_o
);
  logic             full_q, full_d;
  logic [2:0]       dest_q, dest_d;
  logic [nbits-1:0] msg_q, msg_d;
  logic [cbits-1:0] cnt_q, cnt_d;
  logic             fire_in, fire_out;
  // Ready is pipelined: the slot frees on the same edge the held message leaves,
  // so out_rdy -> in_rdy is the only combinational path through the block.
  always_comb begin
    fire_out = full_q && out_rdy_i[dest_q];
    in_rdy_o = !full_q || out_rdy_i[dest_q];
    fire_in  = in_val_i && in_rdy_o;
    full_d   = fire_in ? 1'b1 : (fire_out ? 1'b0 : full_q);
    dest_d   = fire_in ? in_sel_i : dest_q;
    msg_d    = fire_in ? in_msg_i : msg_q;
    cnt_d    = fire_out ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      full_q <= 1'b0;
      dest_q <= 3'd0;
      msg_q  <= '0;
      cnt_q  <= '0;
    end else begin
      full_q <= full_d;
      dest_q <= dest_d;
      msg_q  <= msg_d;
      cnt_q  <= cnt_d;
    end
  end
  assign out_val_o       = full_q ? (8'b1 << dest_q) : 8'b0;
  assign out_msg_o       = msg_q;
  assign deliver_count_o = cnt_q;
endmodule

// File: tb/tb_valrdy_demux8.sv
// tb_valrdy_demux8: scoreboard bench for valrdy_demux8 using directed vectors
module tb_valrdy_demux8;
  typedef struct packed {
    logic [2:0]  sel;
    logic [15:0] msg;
  } ent_t;
  logic        clk, rst_n, in_val, in_rdy;
  logic [2:0]  in_sel;
  logic [15:0] in_msg, out_msg, cnt;
  logic [7:0]  out_val, out_rdy;
  ent_t        sb[$];
  int          checks = 0, errors = 0, cyc = 0, sent = 0;
  valrdy_demux8 #(.nbits(16), .cbits(16)) dut (
    .clk_i(clk), .rst_ni(rst_n), .in_val_i(in_val), .in_rdy_o(in_rdy),
    .in_sel_i(in_sel), .in_msg_i(in_msg), .out_val_o(out_val),
    .out_rdy_i(out_rdy), .out_msg_o(out_msg), .deliver_count_o(cnt)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  // Monitor: any handshake on an output port must match the oldest accepted message.
  always @(negedge clk) begin
    if (rst_n && (out_val & out_rdy) != 8'h00) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_delivery: got out_val=%h msg=%h expected none", out_val, out_msg);
      end else begin
        ent_t e;
        e = sb.pop_front();
        chk("deliver_val", {24'h0, out_val}, 32'h1 << e.sel);
        chk("deliver_msg", {16'h0, out_msg}, {16'h0, e.msg});
      end
    end
  end
  // Called just after a rising edge; returns just after the edge that accepted the message.
  task automatic send(input logic [2:0] s, input logic [15:0] m);
    int n;
    n = 0;
    in_val = 1'b1;
    in_sel = s;
    in_msg = m;
    @(negedge clk);
    while (!in_rdy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_rdy) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got in_rdy=0 expected 1 within 200 cycles");
    end else begin
      sb.push_back('{sel: s, msg: m});
      sent++;
    end
    @(posedge clk);
    #1;
    in_val = 1'b0;
  endtask
  initial begin
    int start;
    rst_n   = 1'b0;
    in_val  = 1'b0;
    in_sel  = 3'd0;
    in_msg  = 16'h0;
    out_rdy = 8'hFF;
    #3;
    chk("reset_out_val", {24'h0, out_val}, 32'h0);
    chk("reset_out_msg", {16'h0, out_msg}, 32'h0);
    chk("reset_count", {16'h0, cnt}, 32'h0);
    chk("reset_in_rdy", {31'h0, in_rdy}, 32'h1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send(3'd5, 16'hBEEF);
    chk("single_out_val", {24'h0, out_val}, 32'h20);
    chk("single_out_msg", {16'h0, out_msg}, 32'hBEEF);
    @(posedge clk);
    #1;
    chk("single_count", {16'h0, cnt}, 32'd1);
    chk("single_drained", {24'h0, out_val}, 32'h0);
    start = cyc;
    for (int i = 0; i < 8; i++) send(i[2:0], 16'h1000 + 16'(i));
    chk("stream_cycles", 32'(cyc - start), 32'd8);
    @(posedge clk);
    #1;
    chk("stream_count", {16'h0, cnt}, 32'd9);
    out_rdy = 8'hF7;
    send(3'd3, 16'h00A5);
    in_val = 1'b1;
    in_sel = 3'd1;
    in_msg = 16'h0777;
    repeat (4) begin
      @(negedge clk);
      chk("bp_in_rdy", {31'h0, in_rdy}, 32'h0);
      chk("bp_out_val", {24'h0, out_val}, 32'h08);
      chk("bp_out_msg", {16'h0, out_msg}, 32'h00A5);
      chk("bp_count", {16'h0, cnt}, 32'd9);
    end
    @(posedge clk);
    #1;
    out_rdy = 8'hFF;
    @(negedge clk);
    chk("bp_release_in_rdy", {31'h0, in_rdy}, 32'h1);
    sb.push_back('{sel: 3'd1, msg: 16'h0777});
    sent++;
    @(posedge clk);
    #1;
    in_val = 1'b0;
    chk("bp_next_out_val", {24'h0, out_val}, 32'h02);
    chk("bp_next_out_msg", {16'h0, out_msg}, 32'h0777);
    chk("bp_release_count", {16'h0, cnt}, 32'd10);
    @(posedge clk);
    #1;
    chk("bp_drain_count", {16'h0, cnt}, 32'd11);
    out_rdy = 8'hFB;
    send(3'd2, 16'h0222);
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("nonsel_count", {16'h0, cnt}, 32'd11);
      chk("nonsel_out_val", {24'h0, out_val}, 32'h04);
    end
    out_rdy = 8'hFF;
    @(posedge clk);
    #1;
    chk("nonsel_release_count", {16'h0, cnt}, 32'd12);
    while (sent < 65535) send(sent[2:0], sent[15:0]);
    @(posedge clk);
    #1;
    chk("wrap_ffff", {16'h0, cnt}, 32'hFFFF);
    send(3'd0, 16'h0000);
    @(posedge clk);
    #1;
    chk("wrap_zero", {16'h0, cnt}, 32'h0);
    out_rdy = 8'hBF;
    send(3'd6, 16'h6666);
    @(posedge clk);
    #1;
    chk("stall6_out_val", {24'h0, out_val}, 32'h40);
    #1;
    rst_n = 1'b0;
    #1;
    sb.delete();
    chk("areset_out_val", {24'h0, out_val}, 32'h0);
    chk("areset_count", {16'h0, cnt}, 32'h0);
    chk("areset_in_rdy", {31'h0, in_rdy}, 32'h1);
    chk("areset_out_msg", {16'h0, out_msg}, 32'h0);
    @(posedge clk);
    #1;
    rst_n   = 1'b1;
    out_rdy = 8'hFF;
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("post_reset_out_val", {24'h0, out_val}, 32'h0);
      chk("post_reset_count", {16'h0, cnt}, 32'h0);
    end
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
